// File: rtl/res_checker.sv
// ---------------------------------------------------------------------------
// res_checker
//
// On-chip result scoreboard. It watches the processor's retired-result
// stream and compares each result, in order, against a programmable table
// of expected values. At the end of a run it reports pass/fail counts, a
// done flag, and where the first mismatch happened.
//
// Optional build macro: RES_CHECKER_FAIL_DATA_EN
//   defined   -> first_fail_data latches res_in at the first mismatch
//   undefined -> no data register is built; first_fail_data reads 0
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   exp_we          expected-table write strobe (accepted in IDLE/DONE only)
//   exp_addr        expected-table write index (>= NUM_CHECKS is dropped)
//   exp_data        expected value to store
//   start           single-cycle pulse; begins a run from IDLE or DONE
//   res_valid       res_in carries a retired result this cycle
//   res_in          processor result
//   busy            high while a run is in progress
//   done            high once NUM_CHECKS results have been scored
//   all_pass        done with zero mismatches
//   pass_count      number of matching results in this run
//   fail_count      number of mismatching results in this run
//   first_fail_idx  table index of the first mismatch
//   first_fail_data result value at the first mismatch
// ---------------------------------------------------------------------------
module res_checker #(
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 18,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_we,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_in,
    output logic              busy,
    output logic              done,
    output logic              all_pass,
    output logic [ADDR_W:0]   pass_count,
    output logic [ADDR_W:0]   fail_count,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0]   LP_NUM  = (ADDR_W+1)'(NUM_CHECKS);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_CHECKS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_pass;
    logic [ADDR_W:0]   r_fail;
    logic [ADDR_W-1:0] r_ff_idx;
    logic              r_ff_valid;

    // Expected values; deliberately not reset so a table survives rst.
    logic [DATA_W-1:0] r_exp [NUM_CHECKS];

    logic w_tbl_we;
    logic w_start;
    logic w_score;
    logic w_match;
    logic w_first_fail;

    // The table is frozen during a run so the comparison source is stable.
    assign w_tbl_we     = exp_we && (r_state != S_RUN) && ({1'b0, exp_addr} < LP_NUM);
    // start is only honoured outside RUN; it takes priority over res_valid.
    assign w_start      = start && (r_state != S_RUN);
    assign w_score      = res_valid && (r_state == S_RUN);
    assign w_match      = (res_in == r_exp[r_idx]);
    assign w_first_fail = w_score && !w_match && !r_ff_valid;

    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            r_exp[exp_addr] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_ff_idx   <= '0;
            r_ff_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state    <= S_RUN;
                        r_idx      <= '0;
                        r_pass     <= '0;
                        r_fail     <= '0;
                        r_ff_idx   <= '0;
                        r_ff_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_score) begin
                        if (w_match) begin
                            r_pass <= r_pass + 1'b1;
                        end else begin
                            r_fail <= r_fail + 1'b1;
                        end
                        if (w_first_fail) begin
                            r_ff_idx   <= r_idx;
                            r_ff_valid <= 1'b1;
                        end
                        r_idx <= r_idx + 1'b1;
                        // The last result is scored on the same edge that
                        // moves to DONE.
                        if (r_idx == LP_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RES_CHECKER_FAIL_DATA_EN
    logic [DATA_W-1:0] r_ff_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff_data <= '0;
        end else if (w_start) begin
            r_ff_data <= '0;
        end else if (w_first_fail) begin
            r_ff_data <= res_in;
        end
    end

    assign first_fail_data = r_ff_data;
`else
    assign first_fail_data = '0;
`endif

    // All outputs come from registers only; res_in never reaches a pin
    // combinationally.
    assign busy           = (r_state == S_RUN);
    assign done           = (r_state == S_DONE);
    assign all_pass       = done && (r_fail == '0);
    assign pass_count     = r_pass;
    assign fail_count     = r_fail;
    assign first_fail_idx = r_ff_idx;

endmodule

// File: tb/tb_res_checker.sv
module tb_res_checker;

    localparam int DATA_W = 32;
    localparam int NUM    = 18;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              start;
    logic              res_valid;
    logic [DATA_W-1:0] res_in;
    logic              busy;
    logic              done;
    logic              all_pass;
    logic [ADDR_W:0]   pass_count;
    logic [ADDR_W:0]   fail_count;
    logic [ADDR_W-1:0] first_fail_idx;
    logic [DATA_W-1:0] first_fail_data;

    res_checker #(.DATA_W(DATA_W), .NUM_CHECKS(NUM), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .start          (start),
        .res_valid      (res_valid),
        .res_in         (res_in),
        .busy           (busy),
        .done           (done),
        .all_pass       (all_pass),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_data(first_fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pass;
        int          fail;
        int          ffidx;
        logic [31:0] ffdata;
        bit          allp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tbl     [NUM];
    logic [31:0] cur_res [NUM];
    int          vectors    = 0;
    int          miscompares = 0;
    logic        done_q     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: score a whole run as a list comparison against the table.
    function automatic exp_t model();
        exp_t e;
        e.pass = 0; e.fail = 0; e.ffidx = 0; e.ffdata = 0;
        for (int i = 0; i < NUM; i++) begin
            if (cur_res[i] == tbl[i]) e.pass++;
            else begin
                if (e.fail == 0) begin
                    e.ffidx  = i;
`ifdef RES_CHECKER_FAIL_DATA_EN
                    e.ffdata = cur_res[i];
`endif
                end
                e.fail++;
            end
        end
        e.allp = (e.fail == 0);
        return e;
    endfunction

    // Monitor: each new completion is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            if (done && !done_q) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("run end: pass=%0d fail=%0d ffidx=%0d ffdata=0x%08h all_pass=%0b",
                             pass_count, fail_count, first_fail_idx, first_fail_data, all_pass);
                    check("pass_count", 32'(pass_count), 32'(e.pass));
                    check("fail_count", 32'(fail_count), 32'(e.fail));
                    check("sum_counts", 32'(pass_count) + 32'(fail_count), 32'(NUM));
                    check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffidx));
                    check("first_fail_data", first_fail_data, e.ffdata);
                    check("all_pass", 32'(all_pass), 32'(e.allp));
                end
            end
            done_q <= done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit push, input bit with_valid, input logic [31:0] vdata);
        if (push) sb_q.push_back(model());
        start     = 1'b1;
        res_valid = with_valid;
        res_in    = vdata;
        tick();
        start     = 1'b0;
        res_valid = 1'b0;
    endtask

    // Drives the first n entries of cur_res; evt_idx inserts a start pulse
    // plus a table write attempt before that result.
    task automatic drive(input int n, input int gap_pct, input int evt_idx);
        for (int i = 0; i < n; i++) begin
            if (i == evt_idx) begin
                start     = 1'b1;
                exp_we    = 1'b1;
                exp_addr  = '0;
                exp_data  = 32'hDEAD;
                res_valid = 1'b0;
                tick();
                start  = 1'b0;
                exp_we = 1'b0;
                check("busy_after_mid_start", 32'(busy), 32'd1);
            end
            while ($urandom_range(99) < gap_pct) begin
                res_valid = 1'b0;
                res_in    = $urandom;
                tick();
            end
            res_valid = 1'b1;
            res_in    = cur_res[i];
            tick();
        end
        res_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 100 && !done; c++) tick();
        check("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{32'd0, 32'd3, 32'd2, 32'd6, 32'd7, 32'd8, 32'd13, 32'd8, 32'd0,
                32'd2, 32'd7, 32'd1, 32'hFFFFFFF2, 32'd1, 32'hFFFFF8D7, 32'd1,
                32'hFFFFFB25, 32'h30};
        rst = 1'b1; exp_we = 0; exp_addr = 0; exp_data = 0;
        start = 0; res_valid = 0; res_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_all_pass", 32'(all_pass), 32'd0);
        check("rst_pass", 32'(pass_count), 32'd0);
        check("rst_fail", 32'(fail_count), 32'd0);
        check("rst_ffidx", 32'(first_fail_idx), 32'd0);
        rst = 1'b0;

        // Load table, plus an out-of-range write that must be dropped.
        for (int i = 0; i < NUM; i++) begin
            exp_we = 1'b1; exp_addr = ADDR_W'(i); exp_data = tbl[i];
            tick();
        end
        exp_addr = 5'd20; exp_data = 32'hBAD0BAD0;
        tick();
        exp_we = 1'b0;

        // Results before start are ignored.
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_in = tbl[i];
            tick();
        end
        res_valid = 1'b0;
        check("idle_pass_unchanged", 32'(pass_count), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Scenario 1: clean pass.
        cur_res = tbl;
        start_run(1, 0, 0);
        drive(NUM, 0, -1);
        wait_done();

        // DONE holds and ignores res_valid.
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_in = $urandom;
            tick();
        end
        res_valid = 1'b0;
        check("done_hold", 32'(done), 32'd1);
        check("done_pass_hold", 32'(pass_count), 32'(NUM));

        // Scenario 2: two mismatches.
        cur_res = tbl;
        cur_res[12] = 32'hFFFFFFF3;
        cur_res[17] = 32'h31;
        start_run(1, 0, 0);
        drive(NUM, 0, -1);
        wait_done();

        // Scenario 3: gaps between results.
        cur_res = tbl;
        start_run(1, 0, 0);
        drive(NUM, 40, -1);
        wait_done();

        // Scenario 4: start and table write during RUN are ignored; a
        // following clean run proves exp[0] survived.
        start_run(1, 0, 0);
        drive(NUM, 20, 5);
        wait_done();
        start_run(1, 0, 0);
        drive(NUM, 0, -1);
        wait_done();

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM; i++)
                cur_res[i] = ($urandom_range(3) == 0) ? 32'($urandom) : tbl[i];
            start_run(1, 0, 0);
            drive(NUM, 25, -1);
            wait_done();
        end

        // Scenario 5: asynchronous reset mid-run at idx 9.
        cur_res = tbl;
        start_run(0, 0, 0);
        drive(9, 0, -1);
        check("pre_reset_pass", 32'(pass_count), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_pass", 32'(pass_count), 32'd0);
        check("async_rst_fail", 32'(fail_count), 32'd0);
        tick();
        rst = 1'b0;
        start_run(1, 0, 0);
        drive(NUM, 0, -1);
        wait_done();

        // Scenario 6: start with res_valid in the same cycle from DONE.
        cur_res = tbl;
        start_run(1, 1, tbl[0]);
        check("s6_busy", 32'(busy), 32'd1);
        check("s6_pass_zero", 32'(pass_count), 32'd0);
        check("s6_fail_zero", 32'(fail_count), 32'd0);
        drive(NUM, 0, -1);
        wait_done();

        tick();
        tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
